// File: rtl/controlador_rolagem.sv
// -----------------------------------------------------------------------------
// controlador_rolagem
//
// Sequencer for the panel's shift-register row. It drives the 2-bit mode
// select {ch1,ch0} of the per-flip-flop multiplexers and the shift-enable
// strobe. The row cycles through load/hold (00), right-to-left scroll (01)
// and left-to-right scroll (10). Timing comes from an internal prescaler and
// a column (step) counter.
//
// Parameters:
//   PRESCALE    clock cycles per scroll step (>= 1)
//   COLS        scroll steps per pass (>= 1)
//   PAUSE_STEPS step-ticks held static between passes (>= 0)
//   CNT_W       width of the prescaler, step and pause counters
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous reset, active-low
//   start      level; begins operation from IDLE (ignored while busy)
//   stop       level; aborts to IDLE from any busy state (highest priority)
//   dir        0 = right-to-left (ch=01), 1 = left-to-right (ch=10)
//   ch0, ch1   mode select to the multiplexers (11 is never driven)
//   shift_en   one-cycle strobe; the row samples its mux outputs when high
//   busy       high in every state except IDLE
//   pass_done  one-cycle pulse on the last step of a pass
//   step       steps completed in the current pass
//
// Build option:
//   PING_PONG_EN  when defined, dir is latched only in LOAD and the latched
//                 direction toggles at every pass end (bouncing message).
//
// All outputs come straight from flops. The combinational block computes
// the values for the next cycle, including whether that cycle is a scroll
// tick, so shift_en, step and pass_done change together on the same edge.
// -----------------------------------------------------------------------------
module controlador_rolagem #(
  parameter int PRESCALE    = 4,
  parameter int COLS        = 8,
  parameter int PAUSE_STEPS = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  output logic             ch0,
  output logic             ch1,
  output logic             shift_en,
  output logic             busy,
  output logic             pass_done,
  output logic [CNT_W-1:0] step
);

  // Reject parameter sets whose counters would not fit in CNT_W bits.
  if ((PRESCALE < 1) || (COLS < 1) || (PAUSE_STEPS < 0) ||
      ((PRESCALE - 1) > ((2 ** CNT_W) - 1)) ||
      (COLS > ((2 ** CNT_W) - 1)) ||
      (PAUSE_STEPS > ((2 ** CNT_W) - 1))) begin : g_param_check
    $error("controlador_rolagem: illegal PRESCALE/COLS/PAUSE_STEPS for CNT_W");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SCROLL = 2'd2,
    PAUSE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ZERO       = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] COLS_C     = CNT_W'(COLS);
  // With PAUSE_STEPS = 0 the PAUSE state is never entered; the value is unused.
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'((PAUSE_STEPS > 0) ? (PAUSE_STEPS - 1) : 0);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] presc_r, presc_s;
  logic [CNT_W-1:0] step_r, step_s, step_base_s;
  logic [CNT_W-1:0] pcnt_r, pcnt_s;
  logic             dir_r, dir_s;
  logic [1:0]       ch_r, ch_s;
  logic             shift_en_r, shift_en_s;
  logic             busy_r, busy_s;
  logic             pass_done_r, pass_done_s;
  logic             cur_wrap_s;
  logic             relatch_s;
  logic             stop_hit_s;
  logic             tick_s;

  assign ch0       = ch_r[0];
  assign ch1       = ch_r[1];
  assign shift_en  = shift_en_r;
  assign busy      = busy_r;
  assign pass_done = pass_done_r;
  assign step      = step_r;

  // Next-state, next-counter and next-output computation.
  always_comb begin
    state_s     = state_r;
    presc_s     = presc_r;
    step_base_s = step_r;
    pcnt_s      = pcnt_r;
    dir_s       = dir_r;
    relatch_s   = 1'b0;
    cur_wrap_s  = (presc_r == PRE_LAST);
    stop_hit_s  = stop && (state_r != IDLE);

    case (state_r)
      IDLE: begin
        presc_s     = ZERO;
        step_base_s = ZERO;
        pcnt_s      = ZERO;
        if (start && !stop) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        state_s     = SCROLL;
        presc_s     = ZERO;
        step_base_s = ZERO;
        pcnt_s      = ZERO;
        dir_s       = dir;
      end
      SCROLL: begin
        if (cur_wrap_s) begin
          presc_s = ZERO;
          // The current cycle is the tick that completed the pass.
          if (step_r == COLS_C) begin
            if (PAUSE_STEPS > 0) begin
              state_s = PAUSE;
              pcnt_s  = ZERO;
            end else begin
              state_s     = SCROLL;
              step_base_s = ZERO;
              relatch_s   = 1'b1;
            end
          end else begin
            state_s = SCROLL;
          end
        end else begin
          presc_s = presc_r + ONE;
        end
      end
      PAUSE: begin
        if (cur_wrap_s) begin
          presc_s = ZERO;
          if (pcnt_r == PAUSE_LAST) begin
            state_s     = SCROLL;
            step_base_s = ZERO;
            pcnt_s      = ZERO;
            relatch_s   = 1'b1;
          end else begin
            pcnt_s = pcnt_r + ONE;
          end
        end else begin
          presc_s = presc_r + ONE;
        end
      end
      default: begin
        state_s     = IDLE;
        presc_s     = ZERO;
        step_base_s = ZERO;
        pcnt_s      = ZERO;
        dir_s       = 1'b0;
      end
    endcase

    // stop wins over everything, including a tick due on this edge.
    if (stop_hit_s) begin
      state_s     = IDLE;
      presc_s     = ZERO;
      step_base_s = ZERO;
      pcnt_s      = ZERO;
      dir_s       = 1'b0;
    end else if (relatch_s) begin
`ifdef PING_PONG_EN
      dir_s = ~dir_r;
`else
      dir_s = dir;
`endif
    end else begin
      dir_s = dir_s;
    end

    // Next cycle is a tick when it is a SCROLL cycle on the prescaler wrap.
    tick_s = (state_s == SCROLL) && (presc_s == PRE_LAST);
    if (tick_s) begin
      step_s = step_base_s + ONE;
    end else begin
      step_s = step_base_s;
    end

    if (state_s == SCROLL) begin
      ch_s = dir_s ? 2'b10 : 2'b01;
    end else begin
      ch_s = 2'b00;
    end

    shift_en_s  = (state_s == LOAD) || tick_s;
    busy_s      = (state_s != IDLE);
    pass_done_s = tick_s && (step_s == COLS_C);
  end

  // State, counters, latched direction and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      presc_r     <= ZERO;
      step_r      <= ZERO;
      pcnt_r      <= ZERO;
      dir_r       <= 1'b0;
      ch_r        <= 2'b00;
      shift_en_r  <= 1'b0;
      busy_r      <= 1'b0;
      pass_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      presc_r     <= presc_s;
      step_r      <= step_s;
      pcnt_r      <= pcnt_s;
      dir_r       <= dir_s;
      ch_r        <= ch_s;
      shift_en_r  <= shift_en_s;
      busy_r      <= busy_s;
      pass_done_r <= pass_done_s;
    end
  end

endmodule

// File: tb/tb_controlador_rolagem.sv
// -----------------------------------------------------------------------------
// tb_controlador_rolagem
//
// Two instances: "a" with PRESCALE=4, COLS=8, PAUSE_STEPS=2 and "b" with
// PRESCALE=1, COLS=1, PAUSE_STEPS=0. Stimulus pushes the expected per-cycle
// output word {ch1,ch0,shift_en,busy,pass_done,step} into a queue per
// instance; a negedge monitor pops and compares one word per cycle.
// -----------------------------------------------------------------------------
module tb_controlador_rolagem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, stop_a, dir_a;
  logic       ch0_a, ch1_a, shift_en_a, busy_a, pass_done_a;
  logic [7:0] step_a;
  logic       start_b, stop_b, dir_b;
  logic       ch0_b, ch1_b, shift_en_b, busy_b, pass_done_b;
  logic [7:0] step_b;

  controlador_rolagem #(.PRESCALE(4), .COLS(8), .PAUSE_STEPS(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .dir(dir_a),
    .ch0(ch0_a), .ch1(ch1_a), .shift_en(shift_en_a), .busy(busy_a),
    .pass_done(pass_done_a), .step(step_a)
  );

  controlador_rolagem #(.PRESCALE(1), .COLS(1), .PAUSE_STEPS(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .dir(dir_b),
    .ch0(ch0_b), .ch1(ch1_b), .shift_en(shift_en_b), .busy(busy_b),
    .pass_done(pass_done_b), .step(step_b)
  );

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int cyc_a  = 0;
  int cyc_b  = 0;

  logic [12:0] q_a[$];
  logic [12:0] q_b[$];
  logic [12:0] obs_a, obs_b, exp_a, exp_b;

  assign obs_a = {ch1_a, ch0_a, shift_en_a, busy_a, pass_done_a, step_a};
  assign obs_b = {ch1_b, ch0_b, shift_en_b, busy_b, pass_done_b, step_b};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] pk(input logic [1:0] ch, input logic se, input logic bz,
                                     input logic pd, input logic [7:0] st);
    return {ch, se, bz, pd, st};
  endfunction

  // Scoreboard monitor: one expected word per cycle while entries are queued.
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      exp_a = q_a.pop_front();
      check_val($sformatf("a_cyc%0d", cyc_a), obs_a, exp_a);
      cyc_a++;
    end
    if (q_b.size() > 0) begin
      exp_b = q_b.pop_front();
      check_val($sformatf("b_cyc%0d", cyc_b), obs_b, exp_b);
      cyc_b++;
    end
  end

  // Invariants over every cycle: no 11 select, no strobes while not busy.
  always @(negedge clk) begin
    if (rst_n) begin
      if (({ch1_a, ch0_a} == 2'b11) || ((shift_en_a || pass_done_a) && !busy_a)) viol++;
      if (({ch1_b, ch0_b} == 2'b11) || ((shift_en_b || pass_done_b) && !busy_b)) viol++;
    end
  end

  // Cycles 1..n of a scroll pass on instance a (PRESCALE=4, COLS=8).
  task automatic push_scroll_a(input logic [1:0] ch, input int n);
    for (int c = 1; c <= n; c++) begin
      int  ph;
      int  st;
      logic se;
      ph = (c - 1) % 4;
      se = (ph == 3);
      st = (c - 1) / 4 + (se ? 1 : 0);
      q_a.push_back(pk(ch, se, 1'b1, se && (st == 8), 8'(st)));
    end
  endtask

  task automatic push_pause_a();
    for (int c = 0; c < 8; c++) q_a.push_back(pk(2'b00, 1'b0, 1'b1, 1'b0, 8'd8));
  endtask

  task automatic push_idle_a(input int n);
    for (int c = 0; c < n; c++) q_a.push_back(pk(2'b00, 1'b0, 1'b0, 1'b0, 8'd0));
  endtask

  // Advance to the middle of cycle k (cycle 0 follows the first edge after the drive).
  task automatic adv(inout int at, input int k);
    while (at < k + 1) begin
      @(negedge clk);
      at++;
    end
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (((q_a.size() > 0) || (q_b.size() > 0)) && (g < 2000)) begin
      @(negedge clk);
      g++;
    end
    check_val("drain", q_a.size() + q_b.size(), 0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int at;
    logic [1:0] ch3;
    rst_n   = 1'b0;
    start_a = 1'b0; stop_a = 1'b0; dir_a = 1'b0;
    start_b = 1'b0; stop_b = 1'b0; dir_b = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_a", obs_a, 13'd0);
    check_val("rst_b", obs_b, 13'd0);
    #1 rst_n = 1'b1;
    push_idle_a(2);
    q_b.push_back(pk(2'b00, 1'b0, 1'b0, 1'b0, 8'd0));
    drain();

    // Async reset mid-SCROLL at step 3.
    start_a = 1'b1; dir_a = 1'b0; at = 0;
    q_a.push_back(pk(2'b00, 1'b1, 1'b1, 1'b0, 8'd0));
    push_scroll_a(2'b01, 13);
    adv(at, 0); start_a = 1'b0;
    adv(at, 13);
    check_val("pre_rst_step", step_a, 8'd3);
    #2 rst_n = 1'b0;
    #1 check_val("rst_async", obs_a, 13'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    push_idle_a(2);
    drain();

    // Three passes with pauses, dir change mid-pass, start while busy, stop on a tick edge.
    start_a = 1'b1; dir_a = 1'b0; at = 0;
`ifdef PING_PONG_EN
    ch3 = 2'b01;
`else
    ch3 = 2'b10;
`endif
    q_a.push_back(pk(2'b00, 1'b1, 1'b1, 1'b0, 8'd0));
    push_scroll_a(2'b01, 32);
    push_pause_a();
    push_scroll_a(2'b10, 32);
    push_pause_a();
    push_scroll_a(ch3, 11);
    push_idle_a(6);
    adv(at, 0);  start_a = 1'b0;
    adv(at, 14); dir_a = 1'b1;
    adv(at, 50); start_a = 1'b1;
    adv(at, 51); start_a = 1'b0;
    adv(at, 91); stop_a = 1'b1;
    adv(at, 93); start_a = 1'b1;
    adv(at, 96); start_a = 1'b0; stop_a = 1'b0; dir_a = 1'b0;
    drain();

    // Degenerate timing: a tick and a pass end on every SCROLL cycle.
    start_b = 1'b1; dir_b = 1'b0; at = 0;
    q_b.push_back(pk(2'b00, 1'b1, 1'b1, 1'b0, 8'd0));
    for (int c = 1; c <= 6; c++) begin
`ifdef PING_PONG_EN
      q_b.push_back(pk(((c % 2) == 1) ? 2'b01 : 2'b10, 1'b1, 1'b1, 1'b1, 8'd1));
`else
      q_b.push_back(pk(2'b01, 1'b1, 1'b1, 1'b1, 8'd1));
`endif
    end
    for (int c = 0; c < 3; c++) q_b.push_back(pk(2'b00, 1'b0, 1'b0, 1'b0, 8'd0));
    adv(at, 0); start_b = 1'b0;
    adv(at, 6); stop_b = 1'b1;
    adv(at, 8); stop_b = 1'b0;
    drain();

    check_val("invariants", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controlador_rolagem.md
Name: controlador_rolagem

Overview:
- Sequencer for the panel's shift-register row.
- Drives the 2-bit mode select (ch1/ch0) of the per-flip-flop mode multiplexer and a shift-enable strobe, so the row alternates between load/hold, right-to-left scroll and left-to-right scroll.
- Timing comes from an internal prescaler and a column counter.
- Sits between the top-level user controls and the row of flip-flops/multiplexers.

Parameters:
PRESCALE, 4, clock cycles per scroll step (>=1)
COLS, 8, scroll steps per pass (panel width, >=1)
PAUSE_STEPS, 2, step-ticks held static between passes (>=0)
CNT_W, 8, width of prescaler, step and pause counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active-low
start  in  1  level, sampled each cycle; begins operation from IDLE
stop  in  1  level, sampled each cycle; aborts to IDLE
dir  in  1  0 = right-to-left (ch=01), 1 = left-to-right (ch=10)
ch0  out  1  mode select bit 0 to multiplexers
ch1  out  1  mode select bit 1 to multiplexers
shift_en  out  1  one-cycle strobe; flip-flops sample mux output when high
busy  out  1  high in every state except IDLE
pass_done  out  1  one-cycle pulse on the last step of a pass
step  out  CNT_W  steps completed in current pass

Behaviour:
- All outputs are registered. Reset (rst_n low, asynchronous) forces: state IDLE, ch1=0, ch0=0, shift_en=0, busy=0, pass_done=0, step=0, all internal counters 0, latched direction 0.
- {ch1,ch0}=11 is never driven.
- States: IDLE, LOAD, SCROLL, PAUSE.
- IDLE: ch=00, shift_en=0, busy=0. start=1 and stop=0 -> LOAD.
- LOAD (exactly 1 cycle):
  - ch=00, shift_en=1, so the row captures the display data through the 00 path.
  - dir is latched into dir_q.
  - Prescaler and step are cleared.
  - Next state is SCROLL.
- SCROLL:
  - ch=01 if dir_q=0, ch=10 if dir_q=1.
  - Prescaler counts 0..PRESCALE-1 and wraps. On the wrap cycle, shift_en=1 and step increments.
  - First shift_en occurs PRESCALE cycles after entry.
  - On the tick where step reaches COLS: pass_done=1 that same cycle. Then go to PAUSE if PAUSE_STEPS>0, else directly re-enter SCROLL with step=0 and dir re-latched.
- PAUSE:
  - ch=00, shift_en=0; the row holds because it is not enabled.
  - Counts PAUSE_STEPS prescaler wraps.
  - On the final wrap: step=0, dir re-latched, next state SCROLL.
- dir changes mid-pass have no effect until the next latch point.
- stop=1 in any non-IDLE state: next edge goes to IDLE with ch=00, shift_en=0, counters cleared. stop has priority over start and over a coinciding tick (no shift_en on that edge).
- start while busy: ignored.
- PRESCALE=1: shift_en is high every SCROLL cycle.
- COLS=1: pass_done on every tick.
- Counter wrap never exceeds 2^CNT_W-1. Parameters violating this are illegal; flag with an elaboration-time check.
- pass_done and shift_en are never asserted in IDLE.

Optional Feature:
PING_PONG_EN
- Defined: dir is latched only in LOAD. At each pass end dir_q toggles, so the message bounces (01 pass, 10 pass, 01 ...). The dir input is ignored until the next LOAD.
- Undefined: dir_q is re-latched from dir at every pass boundary as described in Behaviour.

Test Plan:
1. Reset with rst_n=0 mid-SCROLL (ch=01, step=3) -> all outputs 0 and state IDLE immediately, without waiting for clk.
2. PRESCALE=4, COLS=8, PAUSE_STEPS=2, dir=0, start pulse -> 1 LOAD cycle (ch=00, shift_en=1), then ch=01 and shift_en every 4th cycle, 8 strobes, pass_done on the 8th, 8 cycles of ch=00 with no strobes, then ch=01 again.
3. dir toggled 0->1 during step 4 of pass -> remaining steps keep ch=01; next pass uses ch=10. With PING_PONG_EN and dir held 0: passes alternate 01, 10, 01.
4. stop asserted on the same cycle as a prescaler wrap in SCROLL -> no shift_en, next cycle IDLE, ch=00, busy=0, step=0. start and stop high together from IDLE -> stays IDLE.
5. PRESCALE=1, COLS=1, PAUSE_STEPS=0 -> after LOAD, shift_en and pass_done high every cycle with ch held at 01.
6. Assertion run over all scenarios -> {ch1,ch0} never 11; shift_en and pass_done never high while busy=0.
